// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch resolution logic.
// Holds the FSM state enum, the per-instruction prediction metadata and a squash helper.
package branch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] PC_INC               = 32'd4;
    localparam int          DEFAULT_FLUSH_CYCLES = 2;
    localparam int          DEFAULT_CNT_W        = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_target;
    } meta_t;

    // A stage captured while the pipe is being flushed must not carry a live instruction.
    function automatic meta_t gate_valid(meta_t m, logic kill);
        meta_t r;
        r       = m;
        r.valid = m.valid & ~kill;
        return r;
    endfunction

endpackage

// File: rtl/branch_meta_pipe.sv
// Stall/flush-aware shift register carrying BTB prediction metadata from fetch to execute.
// STAGES sets the depth so the same block serves a deeper front end.
module branch_meta_pipe
    import branch_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  stall,
    input  logic  flush,
    input  meta_t fetch_meta,
    output meta_t ex_meta
);

    meta_t [STAGES-1:0] stage;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage <= '0;
        end else if (!stall) begin
            stage[0] <= gate_valid(fetch_meta, flush);
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= gate_valid(stage[i-1], flush);
            end
        end
    end

    assign ex_meta = stage[STAGES-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares each branch's fetch-time prediction with its resolved outcome in EX and
// produces the PC redirect, the pipeline flush, the BTB update and performance counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_hit,
    input  logic [31:0]      if_pred_target,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_imm,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             btb_wr_en,
    output logic [31:0]      btb_wr_pc,
    output logic [31:0]      btb_wr_imm,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    state_t          state, state_next;
    logic [FC_W-1:0] flush_cnt, flush_cnt_next;
    meta_t           fetch_meta, ex_meta;
    logic [31:0]     taken_target, correct_target;
    logic            target_mismatch, resolve, mispredict, btb_write;

    assign fetch_meta = '{valid: if_valid, pc: if_pc, hit: if_hit, pred_target: if_pred_target};

    branch_meta_pipe #(
        .STAGES(2)
    ) u_meta_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .stall     (stall),
        .flush     (flush),
        .fetch_meta(fetch_meta),
        .ex_meta   (ex_meta)
    );

    // A mispredict is either a wrong direction or a taken hit whose cached target went stale.
    assign taken_target    = ex_meta.pc + ex_imm;
    assign correct_target  = ex_taken ? taken_target : ex_meta.pc + PC_INC;
    assign target_mismatch = ex_meta.pred_target != taken_target;
    assign resolve         = (state == RUN) && !stall && ex_meta.valid && ex_is_branch;
    assign mispredict      = (ex_taken != ex_meta.hit) || (ex_taken && ex_meta.hit && target_mismatch);
    assign btb_write       = ex_taken && (!ex_meta.hit || target_mismatch);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (resolve && mispredict) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FC_LOAD;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (flush_cnt == '0) begin
                        state_next = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - FC_W'(1);
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign flush = (state == FLUSH);

    // Redirect and BTB strobes are rebuilt every cycle, so they can only ever pulse once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            btb_wr_en      <= 1'b0;
            btb_wr_pc      <= '0;
            btb_wr_imm     <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= resolve && mispredict;
            btb_wr_en      <= resolve && btb_write;
            if (resolve && mispredict) begin
                redirect_pc <= correct_target;
            end
            if (resolve && btb_write) begin
                btb_wr_pc  <= ex_meta.pc;
                btb_wr_imm <= ex_imm;
            end
            if (resolve && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (resolve && mispredict && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
